bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Round-robin arbiter that shares the single system bus between `MASTER_NUM` master ports. Each master port raises `approval_request` and waits for its `approval_grant`. The arbiter then holds ownership for that master until the bus reports `tx_done`, the master withdraws its request, or an optional watchdog expires. It drives the global `busy` line seen by all master ports and sits between the master ports and the bus multiplexers, which it steers via `grant_id`.

## Interface
- `MASTER_NUM`, 2: number of requesting master ports (2..8).
- `ID_LEN`, 1: width of `grant_id`; must equal clog2(`MASTER_NUM`), minimum 1.
- `TIMEOUT`, 4096: watchdog limit in cycles of ownership (≥2); used only with `ARB_TIMEOUT_EN`.

- `clk`  in  1  single clock for the block, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `approval_request`  in  MASTER_NUM  per-master level request; bit i is master i.
- `tx_done`  in  1  one-cycle pulse from the owning master that its transaction, including all bursts, is complete.
- `approval_grant`  out  MASTER_NUM  one-hot grant, registered; all zero when no owner.
- `busy`  out  1  bus owned; high exactly while any `approval_grant` bit is high.
- `grant_id`  out  ID_LEN  index of the current or last owner; steers the bus muxes.
- `timeout_err`  out  1  one-cycle pulse when the watchdog revokes a grant.

## Operation
- Reset (`reset`=0, asynchronous) gives these values:
  - state = IDLE
  - `approval_grant`=0, `busy`=0, `grant_id`=0, `timeout_err`=0
  - round-robin pointer `last` = MASTER_NUM-1, so master 0 wins first
  - watchdog count = 0
- The FSM has three states: IDLE, OWNED, RELEASE.
- **IDLE:**
  - If any request bit is set, select the first set bit scanning `last`+1, `last`+2, … with wrap modulo MASTER_NUM.
  - Register the one-hot grant, `grant_id`=winner and `busy`=1, then go to OWNED.
  - If no request bit is set, stay in IDLE.
- **OWNED:** the grant stays stable. Exit to RELEASE on the first of:
  - (a) `tx_done`=1
  - (b) owner's `approval_request` bit = 0 (abandon)
  - (c) watchdog expiry
- **RELEASE:**
  - Grant = 0 and `busy`=0 for exactly one cycle.
  - `last` ← `grant_id`; `grant_id` holds its value.
  - Go to IDLE unconditionally.
- Requests from non-owners during OWNED/RELEASE are ignored until the next IDLE; they are not latched.
- A `tx_done` pulse while not in OWNED is ignored.
- If (a), (b) and (c) coincide, the exit is the same; `timeout_err` pulses only if `tx_done`=0 in that cycle.
- Index arithmetic: `last`+k is computed modulo MASTER_NUM, not modulo 2^ID_LEN.

## Timing
- Grant latency: a request sampled high at edge n in IDLE puts grant and `busy` high after edge n, i.e. 1 cycle.
- Release latency: `tx_done` sampled at edge k drops grant/`busy` after edge k. The state returns to IDLE after k+1, and the next grant is visible after k+2. There is therefore a minimum 2-cycle gap with `busy`=0 (RELEASE plus the IDLE arbitration cycle).
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset asserted mid-OWNED:
  - Grant, `busy` and `timeout_err` clear immediately, asynchronously.
  - After deassertion, arbitration restarts from master 0.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - A ceil(log2(TIMEOUT))-bit counter clears on entry to OWNED and increments each OWNED cycle.
  - When the count equals TIMEOUT-1 and `tx_done`=0, go to RELEASE with `timeout_err`=1 for that one RELEASE cycle.
  - A grant held for TIMEOUT cycles is revoked.
- `ARB_TIMEOUT_EN` not defined:
  - No counter is built and `timeout_err` is tied to 0.
  - Ownership is unbounded and ends only by (a) or (b).

## Test plan
- **Reset:** hold `reset`=0 with requests 2'b11 -> all outputs 0. Release reset -> after 1 edge `approval_grant`=2'b01, `busy`=1, `grant_id`=0.
- **Single master:** master 1 requests, `tx_done` pulsed 5 cycles after grant -> grant 2'b10 for 5 cycles, then `busy`=0 for 2 cycles, then regranted 2'b10 because the request is still high.
- **Fairness:** requests held at 2'b11, `tx_done` every 3rd owned cycle -> grants alternate 01,10,01,10 with a 2-cycle gap each time.
- **Abandon:** owner master 0 drops its request mid-OWNED with no `tx_done` -> grant falls the next edge, `timeout_err`=0, and master 1 is granted 2 cycles later.
- **Watchdog** (`ARB_TIMEOUT_EN`, TIMEOUT=8): owner never pulses `tx_done` -> grant held 8 cycles, `timeout_err`=1 for 1 cycle. Same test without the macro -> grant held indefinitely and `timeout_err` never rises.
- **Async reset mid-ownership:** drop `reset` between clock edges while OWNED -> grant and `busy` go to 0 before the next edge, and arbitration restarts at master 0.

Source files
------------

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter: one owner at a time, held until tx_done, abandon, or watchdog.
// Optional watchdog enabled by defining ARB_TIMEOUT_EN (TIMEOUT cycles of ownership max).
`timescale 1ns/1ps

// state   | meaning
// IDLE    | no owner, arbitrate among current requests
// OWNED   | grant held for grant_id
// RELEASE | one dead cycle, round-robin pointer advances
module bus_arbiter #(
  parameter int MASTER_NUM = 2,
  parameter int ID_LEN     = 1,
  parameter int TIMEOUT    = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [MASTER_NUM-1:0] approval_request,
  input  logic                  tx_done,
  output logic [MASTER_NUM-1:0] approval_grant,
  output logic                  busy,
  output logic [ID_LEN-1:0]     grant_id,
  output logic                  timeout_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, OWNED = 2'd1, RELEASE = 2'd2} state_t;

  state_t                r_state, w_state_nxt;
  logic [MASTER_NUM-1:0] r_grant, w_grant_nxt;
  logic                  r_busy, w_busy_nxt;
  logic [ID_LEN-1:0]     r_grant_id, w_grant_id_nxt;
  logic [ID_LEN-1:0]     r_last, w_last_nxt;
  logic [ID_LEN-1:0]     w_win_id;
  logic                  w_owner_req;
  logic                  w_expire;

  if (MASTER_NUM < 2 || MASTER_NUM > 8 || ID_LEN < 1 || TIMEOUT < 2) begin : g_bad_cfg
    $error("bus_arbiter: unsupported parameter set");
  end

  // Scan last+1 .. last+MASTER_NUM (mod MASTER_NUM); the nearest set bit wins.
  always_comb begin
    int idx;
    idx      = 0;
    w_win_id = '0;
    for (int k = MASTER_NUM; k >= 1; k--) begin
      idx = int'(r_last) + k;
      if (idx >= MASTER_NUM) idx = idx - MASTER_NUM;
      if (approval_request[idx]) w_win_id = ID_LEN'(idx);
    end
  end

  assign w_owner_req = |(approval_request & r_grant);

`ifdef ARB_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [TW-1:0] r_wd_cnt;
  logic          r_timeout_err;

  assign w_expire = (r_wd_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wd_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_wd_cnt      <= (r_state == OWNED) ? r_wd_cnt + 1'b1 : '0;
      r_timeout_err <= (r_state == OWNED) && w_expire && !tx_done;
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign w_expire    = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_busy_nxt     = r_busy;
    w_grant_id_nxt = r_grant_id;
    w_last_nxt     = r_last;
    case (r_state)
      IDLE: begin
        if (|approval_request) begin
          w_grant_nxt    = MASTER_NUM'(1) << w_win_id;
          w_busy_nxt     = 1'b1;
          w_grant_id_nxt = w_win_id;
          w_state_nxt    = OWNED;
        end
      end
      OWNED: begin
        if (tx_done || !w_owner_req || w_expire) begin
          w_grant_nxt = '0;
          w_busy_nxt  = 1'b0;
          w_state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        w_last_nxt  = r_grant_id;
        w_state_nxt = IDLE;
      end
      default: begin
        w_grant_nxt = '0;
        w_busy_nxt  = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_busy     <= 1'b0;
      r_grant_id <= '0;
      r_last     <= ID_LEN'(MASTER_NUM - 1);
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_busy     <= w_busy_nxt;
      r_grant_id <= w_grant_id_nxt;
      r_last     <= w_last_nxt;
    end
  end

  assign approval_grant = r_grant;
  assign busy           = r_busy;
  assign grant_id       = r_grant_id;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: scoreboard of expected grants popped on each new grant.
`timescale 1ns/1ps

module tb_bus_arbiter;
  localparam int MN = 2;
  localparam int IL = 1;
  localparam int TO = 8;

  logic          clk;
  logic          reset;
  logic [MN-1:0] approval_request;
  logic          tx_done;
  logic [MN-1:0] approval_grant;
  logic          busy;
  logic [IL-1:0] grant_id;
  logic          timeout_err;

  typedef struct {
    logic [MN-1:0] grant;
    logic [IL-1:0] id;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  bus_arbiter #(.MASTER_NUM(MN), .ID_LEN(IL), .TIMEOUT(TO)) dut (
    .clk              (clk),
    .reset            (reset),
    .approval_request (approval_request),
    .tx_done          (tx_done),
    .approval_grant   (approval_grant),
    .busy             (busy),
    .grant_id         (grant_id),
    .timeout_err      (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input logic [MN-1:0] g, input logic [IL-1:0] id);
    exp_t e;
    e.grant = g;
    e.id    = id;
    exp_q.push_back(e);
  endtask

  // Returns edges until busy rises, or -1 if it never does within the budget.
  task automatic wait_grant(output int n);
    n = -1;
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (busy === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic do_reset();
    reset            = 1'b0;
    approval_request = '0;
    tx_done          = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    int   n;
    reset            = 1'b0;
    approval_request = 2'b11;
    tx_done          = 1'b0;
    tick(); tick(); tick();
    checks++; if (approval_grant !== 2'b00) begin errors++; $display("FAIL reset_grant got %b exp 00", approval_grant); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (grant_id !== 1'b0) begin errors++; $display("FAIL reset_id got %b exp 0", grant_id); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_terr got %b exp 0", timeout_err); end
    sb_push(2'b01, 1'b0);
    reset = 1'b1;
    wait_grant(n);
    checks++; if (n != 1) begin errors++; $display("FAIL reset_latency got %0d exp 1", n); end
    e = exp_q.pop_front();
    checks++; if (approval_grant !== e.grant || grant_id !== e.id)
      begin errors++; $display("FAIL reset_first_grant got %b/%b exp %b/%b", approval_grant, grant_id, e.grant, e.id); end
  endtask

  task automatic test_single();
    exp_t e;
    int   n;
    int   bad;
    do_reset();
    sb_push(2'b10, 1'b1);
    approval_request = 2'b10;
    wait_grant(n);
    checks++; if (n != 1) begin errors++; $display("FAIL single_latency got %0d exp 1", n); end
    e = exp_q.pop_front();
    checks++; if (approval_grant !== e.grant || grant_id !== e.id)
      begin errors++; $display("FAIL single_grant got %b/%b exp %b/%b", approval_grant, grant_id, e.grant, e.id); end
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (approval_grant !== 2'b10 || busy !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL single_hold got %0d unstable cycles exp 0", bad); end
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    checks++; if (approval_grant !== 2'b00 || busy !== 1'b0)
      begin errors++; $display("FAIL single_release got %b/%b exp 00/0", approval_grant, busy); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL single_terr got %b exp 0", timeout_err); end
    sb_push(2'b10, 1'b1);
    wait_grant(n);
    checks++; if (n != 2) begin errors++; $display("FAIL single_gap got %0d exp 2", n); end
    e = exp_q.pop_front();
    checks++; if (approval_grant !== e.grant || grant_id !== e.id)
      begin errors++; $display("FAIL single_regrant got %b/%b exp %b/%b", approval_grant, grant_id, e.grant, e.id); end
  endtask

  task automatic test_fairness();
    exp_t e;
    int   n;
    int   lat;
    do_reset();
    sb_push(2'b01, 1'b0);
    sb_push(2'b10, 1'b1);
    sb_push(2'b01, 1'b0);
    sb_push(2'b10, 1'b1);
    approval_request = 2'b11;
    for (int i = 0; i < 4; i++) begin
      lat = (i == 0) ? 1 : 2;
      wait_grant(n);
      checks++; if (n != lat) begin errors++; $display("FAIL fair_latency[%0d] got %0d exp %0d", i, n, lat); end
      e = exp_q.pop_front();
      checks++; if (approval_grant !== e.grant || grant_id !== e.id)
        begin errors++; $display("FAIL fair_grant[%0d] got %b/%b exp %b/%b", i, approval_grant, grant_id, e.grant, e.id); end
      tick();
      tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
    end
  endtask

  task automatic test_abandon();
    exp_t e;
    int   n;
    do_reset();
    sb_push(2'b01, 1'b0);
    approval_request = 2'b11;
    wait_grant(n);
    checks++; if (n != 1) begin errors++; $display("FAIL abandon_latency got %0d exp 1", n); end
    e = exp_q.pop_front();
    checks++; if (approval_grant !== e.grant || grant_id !== e.id)
      begin errors++; $display("FAIL abandon_first got %b/%b exp %b/%b", approval_grant, grant_id, e.grant, e.id); end
    tick();
    tick();
    sb_push(2'b10, 1'b1);
    approval_request = 2'b10;
    tick();
    checks++; if (approval_grant !== 2'b00 || busy !== 1'b0)
      begin errors++; $display("FAIL abandon_drop got %b/%b exp 00/0", approval_grant, busy); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL abandon_terr got %b exp 0", timeout_err); end
    wait_grant(n);
    checks++; if (n != 2) begin errors++; $display("FAIL abandon_gap got %0d exp 2", n); end
    e = exp_q.pop_front();
    checks++; if (approval_grant !== e.grant || grant_id !== e.id)
      begin errors++; $display("FAIL abandon_next got %b/%b exp %b/%b", approval_grant, grant_id, e.grant, e.id); end
  endtask

  task automatic test_watchdog();
    exp_t e;
    int   n;
    do_reset();
    sb_push(2'b01, 1'b0);
    approval_request = 2'b01;
    wait_grant(n);
    checks++; if (n != 1) begin errors++; $display("FAIL wd_latency got %0d exp 1", n); end
    e = exp_q.pop_front();
    checks++; if (approval_grant !== e.grant || grant_id !== e.id)
      begin errors++; $display("FAIL wd_grant got %b/%b exp %b/%b", approval_grant, grant_id, e.grant, e.id); end
`ifdef ARB_TIMEOUT_EN
    begin
      int held;
      int early;
      held  = 1;
      early = 0;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (busy !== 1'b1) break;
        held++;
        if (timeout_err !== 1'b0) early++;
      end
      checks++; if (held != TO) begin errors++; $display("FAIL wd_held got %0d exp %0d", held, TO); end
      checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL wd_terr_pulse got %b exp 1", timeout_err); end
      checks++; if (early != 0) begin errors++; $display("FAIL wd_terr_early got %0d exp 0", early); end
      tick();
      checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL wd_terr_width got %b exp 0", timeout_err); end
      sb_push(2'b01, 1'b0);
      wait_grant(n);
      checks++; if (n != 1) begin errors++; $display("FAIL wd_regrant_latency got %0d exp 1", n); end
      e = exp_q.pop_front();
      checks++; if (approval_grant !== e.grant || grant_id !== e.id)
        begin errors++; $display("FAIL wd_regrant got %b/%b exp %b/%b", approval_grant, grant_id, e.grant, e.id); end
    end
`else
    begin
      int bad;
      int terr_seen;
      bad       = 0;
      terr_seen = 0;
      for (int i = 0; i < 30; i++) begin
        tick();
        if (approval_grant !== 2'b01 || busy !== 1'b1) bad++;
        if (timeout_err !== 1'b0) terr_seen++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL wd_unbounded got %0d dropped cycles exp 0", bad); end
      checks++; if (terr_seen != 0) begin errors++; $display("FAIL wd_terr_tied got %0d pulses exp 0", terr_seen); end
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wd_txdone_release got %b exp 0", busy); end
    end
`endif
  endtask

  task automatic test_async_reset();
    exp_t e;
    int   n;
    do_reset();
    sb_push(2'b01, 1'b0);
    sb_push(2'b10, 1'b1);
    approval_request = 2'b11;
    wait_grant(n);
    e = exp_q.pop_front();
    checks++; if (approval_grant !== e.grant || grant_id !== e.id)
      begin errors++; $display("FAIL arst_first got %b/%b exp %b/%b", approval_grant, grant_id, e.grant, e.id); end
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    wait_grant(n);
    e = exp_q.pop_front();
    checks++; if (approval_grant !== e.grant || grant_id !== e.id)
      begin errors++; $display("FAIL arst_second got %b/%b exp %b/%b", approval_grant, grant_id, e.grant, e.id); end
    tick();
    #3;
    reset = 1'b0;
    #1;
    checks++; if (approval_grant !== 2'b00 || busy !== 1'b0 || timeout_err !== 1'b0)
      begin errors++; $display("FAIL arst_async_clear got %b/%b/%b exp 00/0/0", approval_grant, busy, timeout_err); end
    checks++; if (grant_id !== 1'b0) begin errors++; $display("FAIL arst_id got %b exp 0", grant_id); end
    sb_push(2'b01, 1'b0);
    tick();
    reset = 1'b1;
    wait_grant(n);
    checks++; if (n != 1) begin errors++; $display("FAIL arst_latency got %0d exp 1", n); end
    e = exp_q.pop_front();
    checks++; if (approval_grant !== e.grant || grant_id !== e.id)
      begin errors++; $display("FAIL arst_restart got %b/%b exp %b/%b", approval_grant, grant_id, e.grant, e.id); end
  endtask

  initial begin
    reset            = 1'b0;
    approval_request = '0;
    tx_done          = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_abandon();
    test_watchdog();
    test_async_reset();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d exp 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish exp finish");
    $fatal(1, "simulation time limit");
  end

endmodule
